// File: rtl/source_decoder.sv
// Loop-back Manchester codec: serially encodes one N-bit word MSB first into a
// 2N-bit code register, then walks that register pair by pair to rebuild the word.
module source_decoder #(
  parameter int N = 23
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_enable,
  input  logic [N-1:0]   i_data,
  output logic           o_sign,
  output logic           o_value,
  output logic           o_prev_value,
  output logic [2*N-1:0] o_coded_data,
  output logic           o_enc_done,
  input  logic           i_decode_enable,
  output logic [1:0]     o_decode_buffer,
  output logic           o_decoded_value,
  output logic [N-1:0]   o_result,
  output logic           o_dec_done,
  output logic           o_dec_error
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_TOP  = IW'(N - 1);
  localparam logic [IW-1:0] IDX_NEXT = IW'(N - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Manchester pair for one data bit: 1 -> 10, 0 -> 01.
  function automatic logic [1:0] manchester_pair(input logic bit_in);
    return bit_in ? 2'b10 : 2'b01;
  endfunction

  // Only 10 and 01 are legal code pairs.
  function automatic logic pair_invalid(input logic [1:0] pair);
    return (pair[1] == pair[0]);
  endfunction

  state_t          r_enc_state;
  logic [IW-1:0]   r_enc_idx;
  logic [N-1:0]    r_shadow;
  logic            r_sign;
  logic            r_value;
  logic            r_prev_value;
  logic [2*N-1:0]  r_coded;
  logic            r_enc_done;

  state_t          r_dec_state;
  logic [IW-1:0]   r_dec_idx;
  logic [1:0]      r_dec_buffer;
  logic            r_decoded_value;
  logic [N-1:0]    r_result;
  logic            r_dec_done;
  logic            r_dec_error;

  logic            w_enc_bit;
  logic [IW-1:0]   w_enc_pos;
  logic [1:0]      w_dec_pair;

  // Bit and pair position being encoded this cycle; IDLE encodes the live MSB.
  always_comb begin
    w_enc_bit = 1'b0;
    w_enc_pos = IDX_TOP;
    if (r_enc_state == ST_IDLE) begin
      w_enc_bit = i_data[N-1];
      w_enc_pos = IDX_TOP;
    end else begin
      w_enc_bit = r_shadow[r_enc_idx];
      w_enc_pos = r_enc_idx;
    end
  end

  // Code pair currently addressed by the decoder index.
  always_comb begin
    w_dec_pair = r_coded[{r_dec_idx, 1'b0} +: 2];
  end

  // Encoder FSM; outputs move only on enabled advances.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_enc_state  <= ST_IDLE;
      r_enc_idx    <= IDX_TOP;
      r_shadow     <= '0;
      r_sign       <= 1'b0;
      r_value      <= 1'b0;
      r_prev_value <= 1'b0;
      r_coded      <= '0;
      r_enc_done   <= 1'b0;
    end else begin
      case (r_enc_state)
        ST_IDLE: begin
          if (i_enable) begin
            r_shadow                     <= i_data;
            r_coded[{w_enc_pos, 1'b0} +: 2] <= manchester_pair(w_enc_bit);
            r_prev_value                 <= r_value;
            r_value                      <= w_enc_bit;
            r_sign                       <= w_enc_bit ^ r_value;
            r_enc_idx                    <= IDX_NEXT;
            r_enc_state                  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_enable) begin
            r_coded[{w_enc_pos, 1'b0} +: 2] <= manchester_pair(w_enc_bit);
            r_prev_value                 <= r_value;
            r_value                      <= w_enc_bit;
            r_sign                       <= w_enc_bit ^ r_value;
            if (r_enc_idx == '0) begin
              r_enc_state <= ST_DONE;
              r_enc_done  <= 1'b1;
            end else begin
              r_enc_idx <= r_enc_idx - IW'(1);
            end
          end
        end
        ST_DONE: begin
          r_enc_done <= 1'b1;
        end
        default: begin
          r_enc_state <= ST_IDLE;
          r_enc_idx   <= IDX_TOP;
        end
      endcase
    end
  end

  // Decoder FSM; reads the code register live, no handshake with the encoder.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dec_state     <= ST_IDLE;
      r_dec_idx       <= IDX_TOP;
      r_dec_buffer    <= 2'b00;
      r_decoded_value <= 1'b0;
      r_result        <= '0;
      r_dec_done      <= 1'b0;
      r_dec_error     <= 1'b0;
    end else begin
      case (r_dec_state)
        ST_IDLE, ST_RUN: begin
          if (i_decode_enable) begin
            r_dec_buffer        <= w_dec_pair;
            r_decoded_value     <= (w_dec_pair == 2'b10);
            r_result[r_dec_idx] <= (w_dec_pair == 2'b10);
            if (pair_invalid(w_dec_pair)) begin
              r_dec_error <= 1'b1;
            end
            if (r_dec_idx == '0) begin
              r_dec_state <= ST_DONE;
              r_dec_done  <= 1'b1;
            end else begin
              r_dec_idx   <= r_dec_idx - IW'(1);
              r_dec_state <= ST_RUN;
            end
          end
        end
        ST_DONE: begin
          r_dec_done <= 1'b1;
        end
        default: begin
          r_dec_state <= ST_IDLE;
          r_dec_idx   <= IDX_TOP;
        end
      endcase
    end
  end

  assign o_sign          = r_sign;
  assign o_value         = r_value;
  assign o_prev_value    = r_prev_value;
  assign o_coded_data    = r_coded;
  assign o_enc_done      = r_enc_done;
  assign o_decode_buffer = r_dec_buffer;
  assign o_decoded_value = r_decoded_value;
  assign o_result        = r_result;
  assign o_dec_done      = r_dec_done;
  assign o_dec_error     = r_dec_error;

endmodule

// File: tb/tb_source_decoder.sv
// Directed self-checking bench for source_decoder with hand-computed expectations.
module tb_source_decoder;

  localparam int N = 23;
  localparam logic [N-1:0]   DATA_A  = 23'd8200434;
  localparam logic [2*N-1:0] CODE_A  = 46'b1010101010011001011001010101011010101001011001;
  localparam logic [2*N-1:0] CODE_0  = 46'h155555555555;
  localparam logic [2*N-1:0] CODE_1  = 46'h2AAAAAAAAAAA;
  localparam logic [2*N-1:0] MASK_TOP26 = {26'h3FFFFFF, 20'h00000};

  logic           clk;
  logic           reset;
  logic           enable;
  logic [N-1:0]   data;
  logic           sign;
  logic           value;
  logic           prev_value;
  logic [2*N-1:0] coded_data;
  logic           enc_done;
  logic           decode_enable;
  logic [1:0]     decode_buffer;
  logic           decoded_value;
  logic [N-1:0]   result;
  logic           dec_done;
  logic           dec_error;

  int n_checks;
  int n_fail;

  source_decoder #(.N(N)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_enable        (enable),
    .i_data          (data),
    .o_sign          (sign),
    .o_value         (value),
    .o_prev_value    (prev_value),
    .o_coded_data    (coded_data),
    .o_enc_done      (enc_done),
    .i_decode_enable (decode_enable),
    .o_decode_buffer (decode_buffer),
    .o_decoded_value (decoded_value),
    .o_result        (result),
    .o_dec_done      (dec_done),
    .o_dec_error     (dec_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [2*N-1:0] obs, input logic [2*N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_coded"}, coded_data, '0);
    chk({tag, "_result"}, 46'(result), '0);
    chk({tag, "_flags"},
        46'({sign, value, prev_value, enc_done, decode_buffer, decoded_value, dec_done, dec_error}),
        '0);
  endtask

  task automatic do_reset();
    enable        = 1'b0;
    decode_enable = 1'b0;
    reset         = 1'b1;
    tick(2);
    reset         = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    data          = '0;
    enable        = 1'b0;
    decode_enable = 1'b0;
    reset         = 1'b0;
    #2;

    // Reset state
    do_reset();
    check_reset_state("rst");

    // Full encode of DATA_A
    data   = DATA_A;
    enable = 1'b1;
    tick(1);
    chk("enc_first_pair", 46'(coded_data[45:44]), 46'(2'b10));
    chk("enc_first_rest", 46'(coded_data[43:0]), '0);
    chk("enc_first_value", 46'(value), 46'(1'b1));
    chk("enc_not_done", 46'(enc_done), 46'(1'b0));
    data = 23'h0F0F0F;
    tick(22);
    chk("enc_coded", coded_data, CODE_A);
    chk("enc_done", 46'(enc_done), 46'(1'b1));
    chk("enc_last_bits", 46'({sign, value, prev_value}), 46'(3'b101));
    tick(3);
    chk("enc_done_hold", coded_data, CODE_A);
    enable = 1'b0;

    // Decode after encode
    decode_enable = 1'b1;
    tick(1);
    chk("dec_first_buf", 46'(decode_buffer), 46'(2'b10));
    chk("dec_first_result", 46'(result), 46'(23'h400000));
    tick(4);
    chk("dec_buf5", 46'(decode_buffer), 46'(2'b10));
    tick(1);
    chk("dec_buf6", 46'(decode_buffer), 46'(2'b01));
    chk("dec_val6", 46'(decoded_value), 46'(1'b0));
    chk("dec_not_done", 46'(dec_done), 46'(1'b0));
    tick(17);
    chk("dec_result", 46'(result), 46'(DATA_A));
    chk("dec_done", 46'(dec_done), 46'(1'b1));
    chk("dec_error", 46'(dec_error), 46'(1'b0));
    decode_enable = 1'b0;

    // Pause after bit 10 is encoded
    do_reset();
    data   = DATA_A;
    enable = 1'b1;
    tick(13);
    enable = 1'b0;
    chk("pause_start", coded_data, CODE_A & MASK_TOP26);
    tick(5);
    chk("pause_hold", coded_data, CODE_A & MASK_TOP26);
    chk("pause_no_done", 46'(enc_done), 46'(1'b0));
    enable = 1'b1;
    tick(9);
    chk("pause_almost", 46'(enc_done), 46'(1'b0));
    tick(1);
    chk("pause_coded", coded_data, CODE_A);
    chk("pause_done", 46'(enc_done), 46'(1'b1));
    enable = 1'b0;

    // All-zero word round trip
    do_reset();
    data   = 23'h000000;
    enable = 1'b1;
    tick(23);
    enable = 1'b0;
    chk("zero_coded", coded_data, CODE_0);
    decode_enable = 1'b1;
    tick(23);
    decode_enable = 1'b0;
    chk("zero_result", 46'({result, dec_done, dec_error}), 46'({23'h000000, 1'b1, 1'b0}));

    // All-ones word round trip
    do_reset();
    data   = 23'h7FFFFF;
    enable = 1'b1;
    tick(23);
    enable = 1'b0;
    chk("ones_coded", coded_data, CODE_1);
    decode_enable = 1'b1;
    tick(23);
    decode_enable = 1'b0;
    chk("ones_result", 46'({result, dec_done, dec_error}), 46'({23'h7FFFFF, 1'b1, 1'b0}));

    // Premature decode of an unwritten register
    do_reset();
    decode_enable = 1'b1;
    tick(1);
    decode_enable = 1'b0;
    chk("early_result", 46'(result), '0);
    chk("early_error", 46'(dec_error), 46'(1'b1));
    chk("early_buf", 46'(decode_buffer), 46'(2'b00));

    // Reset during encode of bit 12, with enable still high
    do_reset();
    data   = DATA_A;
    enable = 1'b1;
    tick(11);
    chk("mid_partial", coded_data, CODE_A & {22'h3FFFFF, 24'h000000});
    reset = 1'b1;
    tick(1);
    check_reset_state("mid_rst");
    reset = 1'b0;
    data  = DATA_A;
    tick(23);
    enable = 1'b0;
    chk("mid_rerun_coded", coded_data, CODE_A);
    decode_enable = 1'b1;
    tick(23);
    decode_enable = 1'b0;
    chk("mid_rerun_result", 46'({result, dec_done, dec_error}), 46'({DATA_A, 1'b1, 1'b0}));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/source_decoder.md
# source_decoder

Combined Manchester encoder (Source) and decoder (Decoder) for one 23-bit word. The encoder serially encodes the word, one bit per clock, MSB first, into a 46-bit Manchester code register. The decoder then walks that register pair by pair and rebuilds the 23-bit word. It sits as a loop-back codec for line-coding self-test.

## Interface
- N, 23, data word width; coded width is 2*N.
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  encoder run/advance; encoder pauses (holds state) while low.
- data  in  N  word to encode; captured on the first enabled cycle after reset.
- sign  out  1  1 when the bit being encoded differs from the previous encoded bit.
- value  out  1  data bit encoded on the last advance.
- prev_value  out  1  data bit encoded on the advance before that.
- coded_data  out  2N  Manchester code register; pair [2i+1:2i] encodes data[i].
- enc_done  out  1  all N bits encoded.
- decode_enable  in  1  decoder run/advance; decoder pauses while low.
- decode_buffer  out  2  code pair decoded on the last decoder advance.
- decoded_value  out  1  bit recovered from decode_buffer.
- result  out  N  recovered word.
- dec_done  out  1  all N pairs decoded.
- dec_error  out  1  sticky: an invalid pair (00 or 11) was decoded.

## Operation
- Encoding rule:
  - data bit 1 -> pair 10.
  - data bit 0 -> pair 01.
  - Pair for data[i] goes to coded_data[2i+1:2i], so data MSB lands in coded_data[2N-1:2N-2].
- Encoder states:
  - IDLE: after reset.
  - RUN: index i counting N-1 down to 0.
  - DONE.
- IDLE -> RUN: on the first clk edge with enable=1. That same edge:
  - latches data into an internal shadow register;
  - encodes bit N-1;
  - sets i = N-2.
- RUN, each edge with enable=1:
  - writes the pair for shadow[i];
  - shifts value into prev_value;
  - loads value = shadow[i];
  - sign = value XOR prev_value (using the new values);
  - decrements i.
- RUN -> DONE: on the edge that encodes bit 0. enc_done=1 from then on.
- DONE: holds all outputs. enable is ignored. Only reset restarts the encoder.
- Decoder states: IDLE, RUN (index j counting N-1 down to 0), DONE.
- Decoder, each edge with decode_enable=1 in IDLE/RUN:
  - decode_buffer <= coded_data[2j+1:2j];
  - decoded_value <= (pair == 10);
  - result[j] <= (pair == 10);
  - if pair is 00 or 11, dec_error <= 1;
  - decrements j.
- Decoder -> DONE: after j=0. dec_done=1; holds until reset.
- The decoder reads coded_data live and does not wait for enc_done.
  - Sequencing is the user's responsibility.
  - Decoding an unwritten pair (00) flags dec_error and yields bit 0.
- Reset (any time, including mid-encode/decode):
  - all outputs, the shadow register and both indices return to reset state;
  - both FSMs return to IDLE.
- Reset values: coded_data=0, result=0, sign=value=prev_value=0, decode_buffer=00, decoded_value=0, enc_done=dec_done=dec_error=0.

## Timing
- All outputs registered; no combinational paths from inputs to outputs.
- Encoder latency:
  - pair for data[N-1] is visible after the first enabled edge;
  - coded_data is complete and enc_done=1 after N=23 enabled edges.
- Deasserting enable mid-word freezes i and coded_data. Resuming continues where it stopped; no bit is skipped or repeated.
- Decoder latency:
  - result[N-1] is valid after the first decode_enable edge;
  - full result and dec_done after 23 decode-enabled edges.
- Simultaneous reset with enable/decode_enable: reset wins.
- data changes after capture have no effect until the next reset.

## Test plan
- Encode: reset, data=23'b11111010010000011110010 (8200434), enable high for 23 cycles.
  - Required: coded_data=46'b1010101010011001011001010101011010101001011001 and enc_done=1.
- Decode after encode: decode_enable high for 23 cycles.
  - Required: result=8200434, dec_done=1, dec_error=0.
  - decode_buffer sequence starts 10,10,10,10,10,01.
- Pause: drop enable for 5 cycles after bit 10 has been encoded, then resume.
  - Required: final coded_data identical to the unpaused run.
  - Required: coded_data unchanged during the pause.
- Extremes: data=0 -> coded_data all 01 pairs (46'h155555555555). data=all ones -> all 10 pairs.
  - Required: both round-trip without error.
- Premature decode: decode_enable with no encoding.
  - Required: result=0 and dec_error=1 after the first edge.
- Reset mid-operation: assert reset at encode bit 12.
  - Required: all outputs return to reset values on the next edge.
  - Required: a subsequent full run produces the correct coded_data.
